ospfb_phasecomp_reader: RTL and testbench
=========================================

Name: ospfb_phasecomp_reader

Overview:
- Read side of the ping-pong phase-compensation buffer that sits between the polyphase FIR and the FFT.
- The writer fills bank A or bank B (FILLA/FILLB) with one FFT_LEN frame, then flags that bank full.
- This block reads each full frame out with a circular address rotation that undoes the oversampling phase drift. It streams the frame as AXI4-Stream to the FFT and hands the bank back to the writer.

Parameters:
- FFT_LEN, 64, M: frame length and polyphase branches; power of two.
- DEC_FAC, 48, D: decimation factor, 0 < D <= M. The rotation step is D mod M.
- WIDTH, 16, sample word width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- full_a  in  1  one-cycle pulse: writer has completed bank A.
- full_b  in  1  one-cycle pulse: writer has completed bank B.
- free_a  out  1  level: bank A may be written (not full, not being read).
- free_b  out  1  level: bank B may be written.
- rd_en  out  1  RAM read enable.
- rd_bank  out  1  RAM bank select (0=A, 1=B).
- rd_addr  out  log2(M)  RAM read address.
- rd_data  in  WIDTH  RAM read data, valid exactly one cycle after rd_en.
- m_axis_tdata  out  WIDTH  output sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last sample of frame (n = M-1).
- frame_cnt  out  32  number of completed frames.
- ovf  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release) values:
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, rd_en=0, rd_bank=0, rd_addr=0, frame_cnt=0, ovf=0, free_a=1, free_b=1.
  - Internal: shift=0, next bank=A, both full flags cleared, skid FIFO empty.
- Full flags:
  - full_x pulse sets flag x.
  - A pulse on a bank whose flag is already set, or which is being read, sets ovf; the flag is unchanged.
  - free_x = !flag_x && !(busy && cur_bank==x).
- Bank order: strictly alternating A, B, A, ... starting from A. A full B while waiting on A simply waits.
- FSM (rd_state_t):
  - RD_IDLE -> RD_BUSY when the flag of the expected bank is set. On entry: cur_bank=expected, n=0.
  - RD_BUSY issues reads while the skid FIFO has space counting in-flight reads (occupancy + pending < 2).
  - Read address: rd_addr = (n + shift) mod M, with n running 0..M-1.
  - After the read with n=M-1 is issued, stop issuing and wait for the FIFO to drain that frame's last beat.
  - On the handshake of the tlast beat: clear flag[cur_bank], flip the expected bank, shift = (shift + D) mod M, frame_cnt += 1, go to RD_IDLE.
  - RD_IDLE -> RD_BUSY may occur on the cycle after the tlast handshake. Minimum frame gap is 1 cycle; no bubble inside a frame when tready=1.
- Latency: 3 cycles from full_x pulse to first m_axis_tvalid (flag set, read issue, RAM return into skid output).
- Throughput: 1 sample/cycle under continuous tready.
- AXIS rules:
  - tdata and tlast are held stable while tvalid && !tready.
  - tvalid never depends combinationally on tready.
- Skid: 2-entry FIFO absorbs the one-cycle RAM latency. No sample is lost or duplicated under any tready pattern.
- Arithmetic:
  - Address mod M is a natural log2(M)-bit wrap.
  - Shift update is (shift + D) with conditional subtract of M. For M=64, D=48 the shift sequence is 0, 48, 32, 16, 0, ...
- Simultaneous events:
  - full_x for the finishing bank arriving on the same cycle as its release sets the flag again (release first, then set). It is not an ovf.
  - full_a and full_b in the same cycle are both accepted.
- Reset mid-frame: the partial frame is discarded, tvalid drops immediately, shift returns to 0.

Decomposition:
- Package additions to alpaca_ospfb_constants_pkg:
  - typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;
  - reuse phasecomp_state_t to encode cur_bank (FILLA=A, FILLB=B);
  - localparam ADDR_WID = $clog2(FFT_LEN).
- Sub-module: axis_skid_fifo2, a generic 2-entry valid/ready FIFO of WIDTH+1 bits (data + last).

Test Plan:
- Single frame A, bank preloaded with data=addr, tready=1: pulse full_a → 64 beats with data 0..63, tlast on beat 63, first tvalid 3 cycles after the pulse, free_a deasserted until the tlast handshake.
- Four back-to-back frames A, B, A, B, banks preloaded with data=addr, tready=1: the first beats are 0, 48, 32, 16, and each frame is a contiguous mod-64 sequence. frame_cnt=4. A fifth frame starts at 0 again.
- Random tready with ~50% duty over 8 frames: the scoreboard matches the rotated sequence exactly, with no drops or duplicates. tdata/tlast are stable whenever tvalid && !tready.
- full_b pulsed before full_a: nothing is emitted until full_a. Then A is read, then B. ovf stays 0.
- full_a pulsed twice without a read completing: ovf=1 and stays sticky. Only one frame A is emitted.
- rst_n asserted at beat 20 of frame 1: tvalid=0 at once. After release and full_a, the frame starts at data 0 (shift reset) and frame_cnt=0.

Source files
------------

// File: rtl/ospfb_phasecomp_reader_pkg.sv
// Shared types and default constants for the OSPFB phase-compensation buffer reader.
package ospfb_phasecomp_reader_pkg;

    localparam int unsigned FFT_LEN_DEF = 64;
    localparam int unsigned DEC_FAC_DEF = 48;
    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned ADDR_WID    = $clog2(FFT_LEN_DEF);

    // Bank identity reuses the writer's fill-state encoding.
    typedef enum logic {FILLA, FILLB} phasecomp_state_t;

    typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;

    function automatic phasecomp_state_t other_bank(input phasecomp_state_t b);
        return (b == FILLA) ? FILLB : FILLA;
    endfunction

endpackage

// File: rtl/ospfb_phasecomp_reader_skid.sv
// Generic 2-entry valid/ready FIFO; head register drives the output directly.
module axis_skid_fifo2 #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i,
    output logic [1:0]   count_o
);

    logic         head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   count_q;
    logic         pop;

    // Tail only holds data while the head is occupied; a pop promotes it.
    always_comb begin
        head_vld_d = head_vld_q;
        head_d     = head_q;
        tail_vld_d = tail_vld_q;
        tail_d     = tail_q;
        pop        = head_vld_q && out_ready_i;
        if (pop) begin
            if (tail_vld_q) begin
                head_d     = tail_q;
                tail_vld_d = in_valid_i;
                if (in_valid_i) tail_d = in_data_i;
            end else begin
                head_vld_d = in_valid_i;
                if (in_valid_i) head_d = in_data_i;
            end
        end else if (in_valid_i) begin
            if (!head_vld_q) begin
                head_vld_d = 1'b1;
                head_d     = in_data_i;
            end else begin
                tail_vld_d = 1'b1;
                tail_d     = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
        end else begin
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= 2'(head_vld_d) + 2'(tail_vld_d);
        end
    end

    assign out_valid_o = head_vld_q;
    assign out_data_o  = head_q;
    assign count_o     = count_q;

endmodule

// File: rtl/ospfb_phasecomp_reader.sv
// Ping-pong bank reader: streams each full frame with a rotating start address to AXI4-Stream.
module ospfb_phasecomp_reader
    import ospfb_phasecomp_reader_pkg::*;
#(
    parameter int unsigned FFT_LEN = FFT_LEN_DEF,
    parameter int unsigned DEC_FAC = DEC_FAC_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       full_a,
    input  logic                       full_b,
    output logic                       free_a,
    output logic                       free_b,
    output logic                       rd_en,
    output logic                       rd_bank,
    output logic [$clog2(FFT_LEN)-1:0] rd_addr,
    input  logic [WIDTH-1:0]           rd_data,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [31:0]                frame_cnt,
    output logic                       ovf
);

    localparam int unsigned AW = $clog2(FFT_LEN);
    localparam int unsigned SW = AW + 1;
    localparam logic [AW-1:0] N_LAST = AW'(FFT_LEN - 1);
    localparam logic [SW-1:0] STEP   = SW'(DEC_FAC);
    localparam logic [SW-1:0] MODV   = SW'(FFT_LEN);

    rd_state_t        state_q, state_d;
    phasecomp_state_t cur_bank_q, cur_bank_d, exp_bank_q, exp_bank_d;
    logic [AW-1:0]    n_q, n_d, shift_q, shift_d;
    logic             issued_all_q, issued_all_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic             flag_a_q, flag_a_d, flag_b_q, flag_b_d;
    logic             ovf_q, ovf_d, free_a_q, free_b_q;
    logic             rd_vld_q, rd_last_q;

    logic             fifo_vld, pop, done, start, rel_a, rel_b;
    logic [WIDTH:0]   fifo_dout;
    logic [1:0]       fifo_cnt, occ_eff;
    logic [SW-1:0]    shift_sum;

    assign pop       = fifo_vld && m_axis_tready;
    assign done      = pop && fifo_dout[WIDTH];
    // In-flight reads count against FIFO space; a same-cycle pop frees a slot.
    assign occ_eff   = fifo_cnt + 2'(rd_vld_q) - 2'(pop);
    assign shift_sum = SW'(shift_q) + STEP;

    always_comb begin
        state_d      = state_q;
        cur_bank_d   = cur_bank_q;
        exp_bank_d   = exp_bank_q;
        n_d          = n_q;
        issued_all_d = issued_all_q;
        shift_d      = shift_q;
        frame_cnt_d  = frame_cnt_q;
        rel_a        = 1'b0;
        rel_b        = 1'b0;
        rd_en        = 1'b0;
        start        = (exp_bank_q == FILLA) ? (flag_a_q || full_a) : (flag_b_q || full_b);
        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    state_d      = RD_BUSY;
                    cur_bank_d   = exp_bank_q;
                    n_d          = '0;
                    issued_all_d = 1'b0;
                end
            end
            RD_BUSY: begin
                rd_en = !issued_all_q && (occ_eff < 2'd2);
                if (rd_en) begin
                    n_d          = n_q + AW'(1);
                    issued_all_d = (n_q == N_LAST);
                end
                if (done) begin
                    rel_a       = (cur_bank_q == FILLA);
                    rel_b       = (cur_bank_q == FILLB);
                    exp_bank_d  = other_bank(cur_bank_q);
                    shift_d     = (shift_sum >= MODV) ? AW'(shift_sum - MODV) : AW'(shift_sum);
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    state_d     = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Release happens before a same-cycle full pulse, so that pulse re-arms the flag cleanly.
    always_comb begin
        flag_a_d = (flag_a_q && !rel_a) || full_a;
        flag_b_d = (flag_b_q && !rel_b) || full_b;
        ovf_d    = ovf_q || (full_a && flag_a_q && !rel_a) || (full_b && flag_b_q && !rel_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RD_IDLE;
            cur_bank_q   <= FILLA;
            exp_bank_q   <= FILLA;
            n_q          <= '0;
            issued_all_q <= 1'b0;
            shift_q      <= '0;
            frame_cnt_q  <= '0;
            flag_a_q     <= 1'b0;
            flag_b_q     <= 1'b0;
            ovf_q        <= 1'b0;
            free_a_q     <= 1'b1;
            free_b_q     <= 1'b1;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_bank_q   <= cur_bank_d;
            exp_bank_q   <= exp_bank_d;
            n_q          <= n_d;
            issued_all_q <= issued_all_d;
            shift_q      <= shift_d;
            frame_cnt_q  <= frame_cnt_d;
            flag_a_q     <= flag_a_d;
            flag_b_q     <= flag_b_d;
            ovf_q        <= ovf_d;
            free_a_q     <= !flag_a_d;
            free_b_q     <= !flag_b_d;
            rd_vld_q     <= rd_en;
            rd_last_q    <= rd_en && (n_q == N_LAST);
        end
    end

    axis_skid_fifo2 #(.W(WIDTH + 1)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (rd_vld_q),
        .in_data_i   ({rd_last_q, rd_data}),
        .out_valid_o (fifo_vld),
        .out_data_o  (fifo_dout),
        .out_ready_i (m_axis_tready),
        .count_o     (fifo_cnt)
    );

    assign rd_addr       = n_q + shift_q;
    assign rd_bank       = (cur_bank_q == FILLB);
    assign m_axis_tvalid = fifo_vld;
    assign m_axis_tdata  = fifo_dout[WIDTH-1:0];
    assign m_axis_tlast  = fifo_dout[WIDTH];
    assign frame_cnt     = frame_cnt_q;
    assign ovf           = ovf_q;
    assign free_a        = free_a_q;
    assign free_b        = free_b_q;

endmodule

// File: tb/tb_ospfb_phasecomp_reader.sv
// Directed + randomized bench for ospfb_phasecomp_reader with a frame-level scoreboard.
module tb_ospfb_phasecomp_reader;

    localparam int M = 64;
    localparam int D = 48;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n, full_a, full_b, free_a, free_b, rd_en, rd_bank;
    logic [5:0]    rd_addr;
    logic [W-1:0]  rd_data, m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0]   frame_cnt;
    logic          ovf;

    logic [W-1:0]  mem_a [M];
    logic [W-1:0]  mem_b [M];
    logic [W:0]    exp_q [$];
    logic [W:0]    prev_beat;
    int            errors = 0;
    int            checks = 0;
    int            beats  = 0;
    int            frames_m = 0;
    bit            rand_rdy = 1'b0;
    bit            prev_stall = 1'b0;

    ospfb_phasecomp_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .full_a        (full_a),
        .full_b        (full_b),
        .free_a        (free_a),
        .free_b        (free_b),
        .rd_en         (rd_en),
        .rd_bank       (rd_bank),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_cnt     (frame_cnt),
        .ovf           (ovf)
    );

    always #5 clk = ~clk;

    // Banked RAM with one-cycle read latency.
    always @(posedge clk) if (rd_en) rd_data <= rd_bank ? mem_b[rd_addr] : mem_a[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame k since reset: bank alternates A,B; start offset is k*D mod M.
    task automatic push_frame();
        int sh, idx;
        logic [W-1:0] v;
        sh = (frames_m * D) % M;
        for (int i = 0; i < M; i++) begin
            idx = (i + sh) % M;
            v = (frames_m % 2 == 1) ? mem_b[idx] : mem_a[idx];
            exp_q.push_back({(i == M - 1), v});
        end
        frames_m++;
    endtask

    task automatic step();
        logic [W:0] got;
        logic [W:0] want;
        got = {m_axis_tlast, m_axis_tdata};
        if (prev_stall) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_beat", 32'(got), 32'(prev_beat));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            check("beat_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check("beat", 32'(got), 32'(want));
            end
            beats++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = got;
        @(posedge clk);
        #1;
        full_a = 1'b0;
        full_b = 1'b0;
        if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        full_a = 1'b0;
        full_b = 1'b0;
        rand_rdy = 1'b0;
        m_axis_tready = 1'b1;
        exp_q.delete();
        frames_m = 0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int seen, g, target;
        for (int i = 0; i < M; i++) begin
            mem_a[i] = W'(i);
            mem_b[i] = W'(16'h100 + i);
        end
        do_reset();

        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_frame_cnt", frame_cnt, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_free_a", 32'(free_a), 32'd1);
        check("rst_free_b", 32'(free_b), 32'd1);

        // Single frame A: latency, free_a, contents 0..63.
        full_a = 1'b1;
        push_frame();
        step();
        check("free_a_busy", 32'(free_a), 32'd0);
        check("lat1_tvalid", 32'(m_axis_tvalid), 32'd0);
        step();
        check("lat2_tvalid", 32'(m_axis_tvalid), 32'd0);
        step();
        check("lat3_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("first_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'd0);
        drain("drain_single", 200);
        check("single_frame_cnt", frame_cnt, 32'd1);
        check("single_free_a", 32'(free_a), 32'd1);

        // Back-to-back A,B,A,B then a fifth frame back at shift 0.
        do_reset();
        full_a = 1'b1;
        full_b = 1'b1;
        push_frame();
        push_frame();
        step();
        drain("drain_ab1", 400);
        full_a = 1'b1;
        full_b = 1'b1;
        push_frame();
        push_frame();
        step();
        drain("drain_ab2", 400);
        check("b2b_frame_cnt4", frame_cnt, 32'd4);
        full_a = 1'b1;
        push_frame();
        step();
        drain("drain_fifth", 200);
        check("b2b_frame_cnt5", frame_cnt, 32'd5);
        check("b2b_ovf", 32'(ovf), 32'd0);

        // Random tready over 8 frames, banks refilled with random data while free.
        do_reset();
        rand_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            g = 0;
            while (!((k % 2 == 1) ? free_b : free_a) && g < 3000) begin
                step();
                g++;
            end
            check("rand_free_wait", 32'(g < 3000), 32'd1);
            for (int i = 0; i < M; i++) begin
                if (k % 2 == 1) mem_b[i] = W'($urandom);
                else            mem_a[i] = W'($urandom);
            end
            push_frame();
            if (k % 2 == 1) full_b = 1'b1;
            else            full_a = 1'b1;
            step();
        end
        drain("drain_rand", 4000);
        rand_rdy = 1'b0;
        m_axis_tready = 1'b1;
        check("rand_frame_cnt", frame_cnt, 32'd8);
        check("rand_ovf", 32'(ovf), 32'd0);

        // B marked full before A: B must wait for A.
        do_reset();
        full_b = 1'b1;
        seen = 0;
        repeat (12) begin
            seen += int'(m_axis_tvalid);
            step();
        end
        check("b_waits_for_a", 32'(seen), 32'd0);
        full_a = 1'b1;
        push_frame();
        push_frame();
        step();
        drain("drain_b_first", 400);
        check("b_first_frame_cnt", frame_cnt, 32'd2);
        check("b_first_ovf", 32'(ovf), 32'd0);

        // Second full_a while A is still being read: sticky ovf, one frame only.
        do_reset();
        full_a = 1'b1;
        push_frame();
        step();
        repeat (5) step();
        full_a = 1'b1;
        step();
        check("dup_ovf_set", 32'(ovf), 32'd1);
        drain("drain_dup", 200);
        repeat (10) step();
        check("dup_ovf_sticky", 32'(ovf), 32'd1);
        check("dup_frame_cnt", frame_cnt, 32'd1);

        // Reset at beat 20 of frame 1; next frame restarts at shift 0.
        do_reset();
        full_a = 1'b1;
        push_frame();
        step();
        drain("drain_pre_rst", 200);
        full_b = 1'b1;
        push_frame();
        step();
        target = beats + 20;
        g = 0;
        while (beats < target && g < 500) begin
            step();
            g++;
        end
        check("mid_reach_beat20", 32'(beats >= target), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        do_reset();
        check("mid_rst_frame_cnt", frame_cnt, 32'd0);
        full_a = 1'b1;
        push_frame();
        step();
        drain("drain_post_rst", 200);
        check("post_rst_frame_cnt", frame_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
